// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// with a valid/ready handshake on both sides and a held result in DONE.
module multicycle_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [BW-1:0]    base;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk;

  // One CHUNK-wide slice of the ripple, selected by the chunk counter.
  always_comb begin
    base    = BW'(int'(cnt_q) * CHUNK);
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + ~borrow; inverting B here keeps the datapath an adder.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          work_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d[base +: CHUNK] = s_chunk;
        carry_d = c_chunk;
        if (cnt_q == LAST) begin
          sum_d   = work_d;
          cout_d  = c_chunk;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: 64/8 instance driven from a vector table and
// corner sequences, plus a 16/16 instance checked against a golden model.
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid_t = 1'b0, out_ready_t = 1'b0, cin_t = 1'b0, sub_t = 1'b0;
  logic [63:0] a_t = '0, b_t = '0;

  logic        in_ready64, out_valid64, cout64, ovf64;
  logic [63:0] sum64;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;

  logic        o_ready, o_valid, o_cout, o_ovf;
  logic [63:0] o_sum;

  multicycle_adder #(.WIDTH(64), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_t & ~sel), .in_ready(in_ready64),
    .a(a_t), .b(b_t), .cin(cin_t), .sub(sub_t),
    .out_valid(out_valid64), .out_ready(out_ready_t & ~sel),
    .sum(sum64), .cout(cout64), .ovf(ovf64)
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_t & sel), .in_ready(in_ready16),
    .a(a_t[15:0]), .b(b_t[15:0]), .cin(cin_t), .sub(sub_t),
    .out_valid(out_valid16), .out_ready(out_ready_t & sel),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  assign o_ready = sel ? in_ready16  : in_ready64;
  assign o_valid = sel ? out_valid16 : out_valid64;
  assign o_sum   = sel ? {48'd0, sum16} : sum64;
  assign o_cout  = sel ? cout16 : cout64;
  assign o_ovf   = sel ? ovf16  : ovf64;

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    int          hold;
    bit          keep_valid;
    logic [63:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  res_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Golden model; overflow taken as carry-into-MSB xor carry-out-of-MSB.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input int w);
    res_t        r;
    logic [63:0] mask, am, bm;
    logic [64:0] t;
    logic        c_msb;
    mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am    = a & mask;
    bm    = (sub ? ~b : b) & mask;
    t     = {1'b0, am} + {1'b0, bm} + {64'd0, cin ^ sub};
    r.sum  = t[63:0] & mask;
    r.cout = t[w];
    c_msb  = am[w-1] ^ bm[w-1] ^ r.sum[w-1];
    r.ovf  = c_msb ^ r.cout;
    return r;
  endfunction

  task automatic op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                    input logic sub, input res_t exp, input int hold,
                    input bit keep_valid, input string nm);
    int   lat;
    int   n;
    res_t r;
    lat = sel ? 1 : 8;
    n = 0;
    while (!o_ready && n < 20) begin tick; n++; end
    chk({nm, " in_ready"}, {63'd0, o_ready}, 64'd1);
    a_t = a; b_t = b; cin_t = cin; sub_t = sub; in_valid_t = 1'b1;
    tick;
    sbq.push_back(exp);
    if (!keep_valid) in_valid_t = 1'b0;
    // Operands change right after acceptance and must not disturb the result.
    a_t = {$urandom, $urandom}; b_t = {$urandom, $urandom}; cin_t = ~cin; sub_t = ~sub;
    n = 0;
    while (!o_valid && n < lat + 4) begin
      chk({nm, " busy in_ready"}, {63'd0, o_ready}, 64'd0);
      tick;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat));
    for (int i = 0; i < hold; i++) begin
      chk({nm, " hold out_valid"}, {63'd0, o_valid}, 64'd1);
      chk({nm, " hold in_ready"}, {63'd0, o_ready}, 64'd0);
      chk({nm, " hold sum"}, o_sum, exp.sum);
      tick;
    end
    out_ready_t = 1'b1;
    in_valid_t  = 1'b0;
    r = sbq.pop_front();
    chk({nm, " sum"}, o_sum, r.sum);
    chk({nm, " cout"}, {63'd0, o_cout}, {63'd0, r.cout});
    chk({nm, " ovf"}, {63'd0, o_ovf}, {63'd0, r.ovf});
    tick;
    out_ready_t = 1'b0;
    chk({nm, " release out_valid"}, {63'd0, o_valid}, 64'd0);
    chk({nm, " release in_ready"}, {63'd0, o_ready}, 64'd1);
  endtask

  vec_t vt[8];

  initial begin
    res_t e;
    vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0, 64'd0, 1'b1, 1'b0};
    vt[1] = '{64'd0, 64'd1, 1'b0, 1'b1, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vt[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 5, 1'b1,
              64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 2, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vt[5] = '{64'h0000_0000_0000_00FF, 64'd1, 1'b1, 1'b0, 0, 1'b0, 64'h101, 1'b0, 1'b0};
    vt[6] = '{64'd10, 64'd3, 1'b1, 1'b1, 0, 1'b0, 64'd6, 1'b1, 1'b0};
    vt[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0, 1'b0,
              64'd0, 1'b1, 1'b1};

    // Reset held two cycles.
    rst_n = 1'b0;
    tick; tick;
    chk("reset in_ready", {63'd0, in_ready64}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid64}, 64'd0);
    chk("reset sum", sum64, 64'd0);
    chk("reset cout", {63'd0, cout64}, 64'd0);
    chk("reset ovf", {63'd0, ovf64}, 64'd0);
    chk("reset in_ready16", {63'd0, in_ready16}, 64'd1);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) begin
      e.sum = vt[i].exp_sum; e.cout = vt[i].exp_cout; e.ovf = vt[i].exp_ovf;
      op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, e, vt[i].hold, vt[i].keep_valid,
         $sformatf("vec%0d", i));
    end

    // Abort mid-operation: result must never appear, outputs cleared.
    a_t = 64'h1234; b_t = 64'h1; cin_t = 1'b0; sub_t = 1'b0; in_valid_t = 1'b1;
    tick;
    in_valid_t = 1'b0;
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    chk("abort in_ready", {63'd0, in_ready64}, 64'd1);
    chk("abort out_valid", {63'd0, out_valid64}, 64'd0);
    chk("abort sum", sum64, 64'd0);
    chk("abort ovf", {63'd0, ovf64}, 64'd0);
    // Reset wins over a simultaneous in_valid.
    in_valid_t = 1'b1;
    tick;
    rst_n = 1'b1;
    in_valid_t = 1'b0;
    chk("rst prio in_ready", {63'd0, in_ready64}, 64'd1);
    for (int i = 0; i < 9; i++) begin
      tick;
      chk("abort no result", {63'd0, out_valid64}, 64'd0);
    end
    e.sum = 64'd8; e.cout = 1'b0; e.ovf = 1'b0;
    op(64'd5, 64'd3, 1'b0, 1'b0, e, 0, 1'b0, "post_abort");

    // Single-chunk instance.
    sel = 1'b1;
    tick;
    e.sum = 64'h0; e.cout = 1'b1; e.ovf = 1'b0;
    op(64'hFFFF, 64'h0001, 1'b0, 1'b0, e, 0, 1'b0, "w16_wrap");
    for (int i = 0; i < 24; i++) begin
      logic [63:0] ra, rb;
      logic        rc, rs;
      ra = 64'($urandom_range(0, 65535));
      rb = 64'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (i == 3) begin ra = 64'h7FFF; rb = 64'h0001; rc = 1'b0; rs = 1'b0; end
      if (i == 4) begin ra = 64'h8000; rb = 64'h0001; rc = 1'b0; rs = 1'b1; end
      e = model(ra, rb, rc, rs, 16);
      op(ra, rb, rc, rs, e, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
         $sformatf("w16_rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per clock cycle; WIDTH % CHUNK == 0 required; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands/mode present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in (sub=0) / borrow-in (sub=1).
REQ-010 SHALL have port sub  input  1  0: A+B+cin; 1: A-B-cin.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 SHALL have port cout  output  1  raw carry out of MSB (sub=1: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid=1 at a clock edge SHALL latch a, b^{WIDTH{sub}}, initial carry cin^sub, chunk counter=0, go BUSY.
REQ-018 BUSY: in_ready=0; each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK, LSB chunk first) with running carry, store chunk in working register, increment k.
REQ-019 On the edge completing chunk NCHUNK-1 SHALL copy working result to sum, final carry to cout, compute ovf, go DONE.
REQ-020 Latency: if accepted on edge T, out_valid SHALL be 1 after edge T+NCHUNK (NCHUNK=1 -> after T+1).
REQ-021 ovf SHALL equal (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), B' = effective (possibly inverted) B.
REQ-022 DONE: out_valid=1, in_ready=0; sum/cout/ovf SHALL hold stable while out_ready=0; on out_ready=1 at edge SHALL go IDLE.
REQ-023 in_valid SHALL be ignored in BUSY and DONE; a/b/cin/sub changes after acceptance SHALL not affect the result.
REQ-024 sum/cout/ovf SHALL change only on DONE entry (or reset); working register not visible at outputs.
REQ-025 Chunk counter SHALL be ceil(log2(NCHUNK)) bits min 1, reset to 0 on each acceptance; no wrap past NCHUNK-1.
REQ-026 out_valid and in_ready SHALL never both be 1.

Reset
REQ-027 rst_n=0 at edge SHALL force IDLE, counter=0, working register=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1.
REQ-028 Reset in BUSY or DONE SHALL abort the operation; aborted result never presented.
REQ-029 rst_n has priority over in_valid/out_ready on the same edge.

Verification (WIDTH=64, CHUNK=8 unless noted)
REQ-030 Reset held 2 cycles -> in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
REQ-031 a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 accepted at edge T -> out_valid first 1 after edge T+8, sum=0, cout=1, ovf=0.
REQ-032 sub=1, a=0, b=1, cin=0 -> sum=FFFF_FFFF_FFFF_FFFF, cout=0, ovf=0; sub=1, a=8000_0000_0000_0000, b=1 -> sum=7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
REQ-033 a=7FFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 with out_ready=0 for 5 cycles and in_valid=1 throughout -> sum=8000_0000_0000_0000, ovf=1, stable 5 cycles, no second acceptance until IDLE.
REQ-034 rst_n=0 after 3 BUSY cycles -> IDLE next edge, out_valid stays 0, new operation a=5, b=3 then gives sum=8.
REQ-035 WIDTH=16, CHUNK=16: a=FFFF, b=0001 -> out_valid after 1 cycle, sum=0000, cout=1; random back-to-back ops vs golden model with mid-stream out_ready toggling.
